// File: rtl/serial_demux_8_pkg.sv
// Shared definitions for the serial-to-parallel demultiplexer: state
// encoding and default geometry.
package demux_pkg;

  localparam int N_SLOTS_DEF = 8;
  localparam int SEL_W_DEF   = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

endpackage

// File: rtl/serial_demux_8_if.sv
// Serial input / parallel output bundle for serial_demux_8.
// The master side feeds bits and consumes words; the slave side is the demux.
interface serial_demux_8_if
  import demux_pkg::*;
#(
  parameter int N_SLOTS = N_SLOTS_DEF,
  parameter int SEL_W   = SEL_W_DEF
);

  logic               D;
  logic               D_VALID;
  logic               FRAME;
  logic               D_READY;
  logic [N_SLOTS-1:0] Y;
  logic               Y_VALID;
  logic               Y_READY;
  logic [SEL_W-1:0]   SEL;
  logic               FRAME_ERR;

  modport master (
    output D, D_VALID, FRAME, Y_READY,
    input  D_READY, Y, Y_VALID, SEL, FRAME_ERR
  );

  modport slave (
    input  D, D_VALID, FRAME, Y_READY,
    output D_READY, Y, Y_VALID, SEL, FRAME_ERR
  );

endinterface

// File: rtl/serial_demux_8_demux_1x8.sv
// Slot decoder: turns a slot index plus write enable into one-hot
// write strobes for the shadow register.
module demux_1x8
  import demux_pkg::*;
#(
  parameter int N_SLOTS = N_SLOTS_DEF,
  parameter int SEL_W   = SEL_W_DEF
) (
  input  logic [SEL_W-1:0]   sel_i,
  input  logic               en_i,
  output logic [N_SLOTS-1:0] strobe_o
);

  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_strobe
    assign strobe_o[gi] = en_i && (sel_i == SEL_W'(gi));
  end

endmodule

// File: rtl/serial_demux_8.sv
// Serial-to-parallel demultiplexer: FRAME-aligned bits collect in a shadow
// register and are handed to a separately held output word Y.
module serial_demux_8
  import demux_pkg::*;
#(
  parameter int N_SLOTS = N_SLOTS_DEF,
  parameter int SEL_W   = SEL_W_DEF
) (
  input logic          CLK,
  input logic          RST,
  serial_demux_8_if.slave bus
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_SLOTS - 1);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [N_SLOTS-1:0]   shadow_q, shadow_d;
  logic [N_SLOTS-1:0]   y_q, y_d;
  logic                 y_valid_q, y_valid_d;
  logic                 frame_err_q, frame_err_d;

  logic                 d_ready;
  logic                 accept;
  logic                 restart;
  logic                 wr_en;
  logic [SEL_W-1:0]     wr_sel;
  logic                 complete;
  logic [N_SLOTS-1:0]   strobe;

  // Stall only when the last bit would overwrite a word nobody has taken yet.
  assign d_ready  = !((sel_q == LAST_SLOT) && y_valid_q && !bus.Y_READY);
  assign accept   = bus.D_VALID && d_ready;
  assign restart  = accept && bus.FRAME;
  assign wr_en    = accept && (bus.FRAME || (state_q == COLLECT));
  assign wr_sel   = bus.FRAME ? '0 : sel_q;
  assign complete = wr_en && !bus.FRAME && (sel_q == LAST_SLOT);

  demux_1x8 #(
    .N_SLOTS (N_SLOTS),
    .SEL_W   (SEL_W)
  ) u_demux (
    .sel_i    (wr_sel),
    .en_i     (wr_en),
    .strobe_o (strobe)
  );

  // A FRAME bit wipes any partial word so stale slots never leak into Y.
  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_shadow
    assign shadow_d[gi] = strobe[gi] ? bus.D
                        : (restart ? 1'b0 : shadow_q[gi]);
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    y_d         = y_q;
    y_valid_d   = y_valid_q;
    frame_err_d = 1'b0;

    if (restart) begin
      state_d     = COLLECT;
      sel_d       = SEL_W'(1);
      frame_err_d = (state_q == COLLECT);
    end else if (complete) begin
      state_d = IDLE;
      sel_d   = '0;
    end else if (wr_en) begin
      sel_d = sel_q + SEL_W'(1);
    end

    if (complete) begin
      y_d       = shadow_d;
      y_valid_d = 1'b1;
    end else if (bus.Y_READY) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      shadow_q    <= '0;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      shadow_q    <= shadow_d;
      y_q         <= y_d;
      y_valid_q   <= y_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.D_READY   = d_ready;
  assign bus.Y         = y_q;
  assign bus.Y_VALID   = y_valid_q;
  assign bus.SEL       = sel_q;
  assign bus.FRAME_ERR = frame_err_q;

endmodule

// File: doc/serial_demux_8.md
SERIAL_DEMUX_8 -- requirements
Module: serial_demux_8

Interface
REQ-001 SHALL have parameter N_SLOTS, default 8, number of output slots (one word = N_SLOTS serial bits).
REQ-002 SHALL have parameter SEL_W, default 3, slot-select width, equal to clog2(N_SLOTS).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port D  input  1  serial data bit.
REQ-006 SHALL have port D_VALID  input  1  D is offered this cycle.
REQ-007 SHALL have port FRAME  input  1  qualifies D as slot 0 (first bit) of a word.
REQ-008 SHALL have port D_READY  output  1  block accepts D this cycle.
REQ-009 SHALL have port Y  output  N_SLOTS  parallel word; Y[i] = bit accepted at slot i.
REQ-010 SHALL have port Y_VALID  output  1  Y holds a complete word.
REQ-011 SHALL have port Y_READY  input  1  consumer takes Y this cycle.
REQ-012 SHALL have port SEL  output  SEL_W  slot the next accepted bit is written to.
REQ-013 SHALL have port FRAME_ERR  output  1  one-cycle pulse: FRAME seen mid-word.

Function
REQ-014 SHALL accept a bit exactly when D_VALID and D_READY are both 1 on a rising edge.
REQ-015 SHALL drive D_READY = 0 only when SEL = N_SLOTS-1, Y_VALID = 1 and Y_READY = 0; otherwise D_READY = 1.
REQ-016 SHALL implement states IDLE (no word in progress) and COLLECT (word in progress).
REQ-017 IDLE: accepted bit with FRAME = 0 SHALL be discarded; SEL stays 0; state stays IDLE.
REQ-018 IDLE: accepted bit with FRAME = 1 SHALL be written to shadow slot 0, SEL -> 1, state -> COLLECT.
REQ-019 COLLECT: accepted bit with FRAME = 0 SHALL be written to shadow slot SEL, SEL -> SEL+1.
REQ-020 COLLECT: accepted bit at SEL = N_SLOTS-1 SHALL complete the word: next cycle Y = full shadow word (including this bit), Y_VALID = 1, SEL -> 0, state -> IDLE.
REQ-021 Latency SHALL be exactly 1 cycle from acceptance of the last bit to Y_VALID = 1.
REQ-022 COLLECT: accepted bit with FRAME = 1 SHALL pulse FRAME_ERR for one cycle, discard the partial word, write the bit to slot 0 and set SEL -> 1, state stays COLLECT.
REQ-023 FRAME = 1 on the bit that completes a word at SEL = N_SLOTS-1 SHALL be treated as REQ-022 (resync wins, no word emitted).
REQ-024 Y and Y_VALID SHALL hold stable while Y_VALID = 1 and Y_READY = 0.
REQ-025 Y_VALID SHALL clear on the cycle after Y_READY = 1 unless a new word completes on that same edge, in which case Y loads the new word and Y_VALID stays 1.
REQ-026 Y_READY while Y_VALID = 0 SHALL have no effect.
REQ-027 Bits with D_VALID = 0 SHALL not change SEL, shadow, or state; gaps between bits are unlimited.

Reset
REQ-028 While RST = 1 at a rising edge: state = IDLE, SEL = 0, shadow = 0, Y = 0, Y_VALID = 0, FRAME_ERR = 0.
REQ-029 D_READY SHALL be 1 in the cycle after reset is released.
REQ-030 Reset mid-word or with a pending Y SHALL discard both; no word is emitted.

Structure
REQ-031 Package demux_pkg SHALL hold the state enumeration (IDLE, COLLECT) and the N_SLOTS / SEL_W defaults.
REQ-032 Slot decode SHALL be a sub-module demux_1x8 (combinational: SEL plus write-enable -> N_SLOTS one-hot shadow write strobes).
REQ-033 Shadow register and output register Y SHALL be separate (double-buffered).

Verification
REQ-034 Reset, then 8 bits 1,0,1,0,0,1,0,1 (FRAME on the first) with Y_READY = 1 -> Y = 0xA5, Y_VALID = 1 for one cycle, 1 cycle after the 8th bit.
REQ-035 Two back-to-back words 0xA5, 0x3C, no gaps, Y_READY = 1 -> two Y_VALID pulses, D_READY = 1 throughout.
REQ-036 Word 0xA5 held with Y_READY = 0, then second word 0xFF -> D_READY = 0 at SEL = 7; Y = 0xA5 stable; on Y_READY = 1 -> Y = 0xFF next cycle.
REQ-037 FRAME at the 4th bit of a word, then 7 more bits -> FRAME_ERR pulses once; the emitted word holds the 8 bits from the second FRAME only.
REQ-038 5 bits into a word, RST = 1 for one cycle -> all outputs 0, SEL = 0; a following non-FRAME bit is ignored.
REQ-039 Bits offered without FRAME from IDLE (10 bits) -> no Y_VALID, SEL stays 0, D_READY = 1.
